// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the WB stage and an
//   auxiliary long-latency requester (mul/div, load refill). WB always wins
//   the port; aux writes wait in a small in-order queue and drain into
//   cycles where WB is idle. ID gets a pending-write lookup for interlock and
//   a bubble request when the queued head has been blocked for too long.
//
// Parameters
//   DEPTH         auxiliary queue entries (power of two, >= 2)
//   STARVE_LIMIT  blocked cycles before bubble_request asserts
//
// Ports
//   clock, reset                          clock / async active-high reset
//   wb_write_enabled/address/strobe/data  WB write request (always granted)
//   aux_valid, aux_ready                  aux write handshake
//   aux_address/strobe/data               aux write fields
//   flush                                 discard all queued aux entries
//   lookup_address, lookup_hit            ID pending-write lookup
//   bubble_request                        ask ID for one bubble
//   rf_write_enabled/address/strobe/data  register-file write port
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_write_enabled,
  input  logic [4:0]  wb_write_address,
  input  logic [3:0]  wb_write_strobe,
  input  logic [31:0] wb_write_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_address,
  input  logic [3:0]  aux_strobe,
  input  logic [31:0] aux_data,
  input  logic        flush,
  input  logic [4:0]  lookup_address,
  output logic        lookup_hit,
  output logic        bubble_request,
  output logic        rf_write_enabled,
  output logic [4:0]  rf_write_address,
  output logic [3:0]  rf_write_strobe,
  output logic [31:0] rf_write_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // Queue state
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [STV_W-1:0] starve_reg;
  logic [STV_W-1:0] starve_next;

  // Entry storage; read combinationally at the head and for lookup
  logic [4:0]  addr_mem   [DEPTH];
  logic [3:0]  strobe_mem [DEPTH];
  logic [31:0] data_mem   [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [DEPTH-1:0] entry_hit;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // No same-cycle credit: a pop while full does not open the queue.
  assign aux_ready = !reset && !full && !flush;

  // Writes to r0 complete the handshake but are never stored.
  assign push = aux_valid && aux_ready && (aux_address != 5'd0);

  // Head drains only into cycles WB leaves idle. The queue is empty during
  // reset, so no aux entry can reach the port then.
  assign pop = !reset && !wb_write_enabled && !empty;

  // Write port mux
  always_comb begin
    rf_write_enabled = 1'b0;
    rf_write_address = 5'd0;
    rf_write_strobe  = 4'd0;
    rf_write_data    = 32'd0;
    if (wb_write_enabled) begin
      rf_write_enabled = 1'b1;
      rf_write_address = wb_write_address;
      rf_write_strobe  = wb_write_strobe;
      rf_write_data    = wb_write_data;
    end else if (pop) begin
      rf_write_enabled = 1'b1;
      rf_write_address = addr_mem[head_reg];
      rf_write_strobe  = strobe_mem[head_reg];
      rf_write_data    = data_mem[head_reg];
    end
  end

  // An entry is live when its distance from the head is below the count;
  // pointer arithmetic wraps naturally because DEPTH is a power of two.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lookup
      logic [PTR_W-1:0] offset;
      logic             live;
      assign offset        = PTR_W'(gi) - head_reg;
      assign live          = ({1'b0, offset} < {{(CNT_W-PTR_W){1'b0}}, count_reg[CNT_W-1:0]} );
      assign entry_hit[gi] = live && (addr_mem[gi] == lookup_address);
    end
  endgenerate

  assign lookup_hit     = !reset && (lookup_address != 5'd0) && (|entry_hit);
  assign bubble_request = !reset && (starve_reg == STV_W'(STARVE_LIMIT));

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Counts consecutive cycles the head is held off by WB; saturates.
  always_comb begin
    starve_next = starve_reg;
    if (pop || empty) begin
      starve_next = '0;
    end else if (wb_write_enabled && (starve_reg != STV_W'(STARVE_LIMIT))) begin
      starve_next = starve_reg + STV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
    end else if (flush) begin
      // A head drained during the flush cycle has already committed on the
      // port; everything still queued is dropped.
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      count_reg  <= count_next;
      starve_reg <= starve_next;
    end
  end

  // Payload storage needs no reset: liveness comes from the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_reg]   <= aux_address;
      strobe_mem[tail_reg] <= aux_strobe;
      data_mem[tail_reg]   <= aux_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios followed by random
// traffic, checked per cycle against a queue-based reference model through a
// scoreboard consumed by an independent monitor.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_write_enabled = 1'b0;
  logic [4:0]  wb_write_address = '0;
  logic [3:0]  wb_write_strobe = '0;
  logic [31:0] wb_write_data = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_address = '0;
  logic [3:0]  aux_strobe = '0;
  logic [31:0] aux_data = '0;
  logic        flush = 1'b0;
  logic [4:0]  lookup_address = '0;
  logic        lookup_hit;
  logic        bubble_request;
  logic        rf_write_enabled;
  logic [4:0]  rf_write_address;
  logic [3:0]  rf_write_strobe;
  logic [31:0] rf_write_data;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wb_write_enabled(wb_write_enabled), .wb_write_address(wb_write_address),
    .wb_write_strobe(wb_write_strobe), .wb_write_data(wb_write_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_address(aux_address),
    .aux_strobe(aux_strobe), .aux_data(aux_data), .flush(flush),
    .lookup_address(lookup_address), .lookup_hit(lookup_hit),
    .bubble_request(bubble_request),
    .rf_write_enabled(rf_write_enabled), .rf_write_address(rf_write_address),
    .rf_write_strobe(rf_write_strobe), .rf_write_data(rf_write_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
  } ent_t;

  typedef struct packed {
    logic [41:0] port;   // {enable, address, strobe, data}
    logic        ready;
    logic        hit;
    logic        bubble;
  } exp_t;

  ent_t mq[$];      // reference: pending aux writes, oldest first
  int   streak;     // reference: consecutive blocked cycles of the head
  exp_t sb[$];      // scoreboard: expected outputs, one per driven cycle
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, record the expected outputs, advance the model.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [3:0] ws,
                       input logic [31:0] wd, input logic av, input logic [4:0] aa,
                       input logic [3:0] as_, input logic [31:0] ad, input logic fl,
                       input logic [4:0] la);
    exp_t e;
    logic popped;
    logic was_empty;
    @(posedge clock);
    #1;
    wb_write_enabled = we; wb_write_address = wa; wb_write_strobe = ws; wb_write_data = wd;
    aux_valid = av; aux_address = aa; aux_strobe = as_; aux_data = ad;
    flush = fl; lookup_address = la;

    e.ready  = (mq.size() < DEPTH) && !fl;
    e.hit    = 1'b0;
    if (la != 5'd0) begin
      foreach (mq[i]) if (mq[i].a == la) e.hit = 1'b1;
    end
    e.bubble = (streak >= LIMIT);
    if (we)                 e.port = {1'b1, wa, ws, wd};
    else if (mq.size() > 0) e.port = {1'b1, mq[0].a, mq[0].s, mq[0].d};
    else                    e.port = '0;
    sb.push_back(e);

    was_empty = (mq.size() == 0);
    popped    = !we && !was_empty;
    if (popped) void'(mq.pop_front());
    if (fl) begin
      mq.delete();
      streak = 0;
    end else begin
      if (av && e.ready && aa != 5'd0) mq.push_back('{a: aa, s: as_, d: ad});
      if (popped || was_empty) streak = 0;
      else if (we && streak < LIMIT) streak++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic reset_pulse(input logic [4:0] la);
    @(negedge clock);
    #1;
    wb_write_enabled = 1'b0; aux_valid = 1'b1; aux_address = 5'd20; flush = 1'b0;
    lookup_address = la;
    #1;
    reset = 1'b1;
    #1;
    check("rst_aux_ready", aux_ready, 0);
    check("rst_lookup_hit", lookup_hit, 0);
    check("rst_bubble", bubble_request, 0);
    check("rst_port_idle", {rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data}, 0);
    wb_write_enabled = 1'b1; wb_write_address = 5'd6; wb_write_strobe = 4'h3;
    wb_write_data = 32'hCAFE0006;
    #1;
    check("rst_port_wb", {rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data},
          {1'b1, 5'd6, 4'h3, 32'hCAFE0006});
    mq.delete();
    streak = 0;
    @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0; wb_write_enabled = 1'b0; aux_valid = 1'b0;
    #1;
    check("post_rst_aux_ready", aux_ready, 1);
    check("post_rst_lookup_hit", lookup_hit, 0);
    $display("[TB] t=%0t async reset released", $time);
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rf_port", {rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data}, e.port);
      check("aux_ready", aux_ready, e.ready);
      check("lookup_hit", lookup_hit, e.hit);
      check("bubble_request", bubble_request, e.bubble);
      $display("[TB] t=%0t rf_en=%0d r%0d strb=%h data=%h ready=%0d hit=%0d bubble=%0d",
               $time, rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data,
               aux_ready, lookup_hit, bubble_request);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int busy_pct;
    logic we, av, fl;
    logic [4:0] aa, la;
    streak = 0;

    #3;
    check("reset_aux_ready", aux_ready, 0);
    check("reset_bubble", bubble_request, 0);
    check("reset_port", {rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data}, 0);
    @(negedge clock);
    #1 reset = 1'b0;

    // Idle WB: single aux write drains on the next cycle.
    cycle(0, 0, 0, 0, 1, 5'd5, 4'hF, 32'h11111111, 0, 0);
    idle(2);

    // WB busy three cycles while aux pushes r7, r8, then r9 (refused).
    cycle(1, 5'd3, 4'hF, 32'h33330001, 1, 5'd7, 4'hF, 32'h77777777, 0, 0);
    cycle(1, 5'd3, 4'hF, 32'h33330002, 1, 5'd8, 4'h3, 32'h88888888, 0, 5'd7);
    cycle(1, 5'd3, 4'hF, 32'h33330003, 1, 5'd9, 4'hF, 32'h99999999, 0, 5'd8);
    idle(3);

    // Starvation: one queued entry, WB busy continuously.
    cycle(0, 0, 0, 0, 1, 5'd10, 4'hC, 32'hAAAA0010, 0, 0);
    cycle(1, 5'd1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 5'd10);
    for (int i = 0; i < 10; i++) cycle(1, 5'd1, 4'hF, i, 0, 0, 0, 0, 0, 5'd10);
    idle(2);

    // Lookup and r0 discard.
    cycle(1, 5'd2, 4'hF, 32'h2, 1, 5'd9, 4'hF, 32'h09090909, 0, 0);
    cycle(1, 5'd2, 4'hF, 32'h2, 0, 0, 0, 0, 0, 5'd9);
    cycle(1, 5'd2, 4'hF, 32'h2, 0, 0, 0, 0, 0, 5'd0);
    cycle(1, 5'd2, 4'hF, 32'h2, 1, 5'd0, 4'hF, 32'hDEAD0000, 0, 5'd9);
    idle(3);

    // Flush with a full queue and WB busy.
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd11, 4'hF, 32'hB0B0B0B0, 0, 0);
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd12, 4'hF, 32'hC0C0C0C0, 0, 0);
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd13, 4'hF, 32'hD0D0D0D0, 1, 5'd11);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd11);
    idle(2);

    // Flush while WB idle: head still commits that cycle.
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd14, 4'hF, 32'hE0E0E0E0, 0, 0);
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd15, 4'hF, 32'hF0F0F0F0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd15);
    idle(2);

    // Async reset mid-drain with two queued entries.
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd16, 4'hF, 32'h16161616, 0, 0);
    cycle(1, 5'd4, 4'hF, 32'h4, 1, 5'd17, 4'hF, 32'h17171717, 0, 0);
    reset_pulse(5'd16);
    idle(2);

    // Random traffic in phases of varying WB duty cycle.
    for (int p = 0; p < 12; p++) begin
      case (p % 4)
        0: busy_pct = 30;
        1: busy_pct = 70;
        2: busy_pct = 95;
        default: busy_pct = 100;
      endcase
      for (int i = 0; i < 50; i++) begin
        we = ($urandom_range(0, 99) < busy_pct);
        av = ($urandom_range(0, 1) == 1);
        fl = ($urandom_range(0, 99) < 3);
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        if (mq.size() > 0 && $urandom_range(0, 1) == 1)
          la = mq[$urandom_range(0, mq.size() - 1)].a;
        else
          la = 5'($urandom_range(0, 31));
        cycle(we, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom,
              av, aa, 4'($urandom_range(0, 15)), $urandom, fl, la);
      end
    end
    idle(4);

    @(posedge clock);
    @(negedge clock);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
